// File: rtl/uart_pkg.sv
// Shared receiver state codes, parity mode constants and frame-length helper
// for the configurable UART receiver.
package uart_pkg;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StStart     = 3'd1;
  localparam logic [2:0] StData      = 3'd2;
  localparam logic [2:0] StParity    = 3'd3;
  localparam logic [2:0] StStop      = 3'd4;
  localparam logic [2:0] StBreakWait = 3'd5;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Start + data + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-word delivery bundle: data word, one-cycle valid/error pulses and
// error cause flags.
interface uart_rx_cfg_if #(
  parameter int unsigned P_DATA_BITS = 8
);
  logic [P_DATA_BITS-1:0] Do;
  logic                   valid;
  logic                   error;
  logic                   parity_err;
  logic                   frame_err;
  logic                   break_det;

  modport master (output Do, valid, error, parity_err, frame_err, break_det);
  modport slave  (input  Do, valid, error, parity_err, frame_err, break_det);
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, start-edge detector and mid-bit 3-sample majority voter
// with a restartable oversample counter.
module uart_rx_sampler #(
  parameter int unsigned P_OVERSAMPLE  = 16,
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  input  logic restart,
  output logic synced,
  output logic start_edge,
  output logic bit_value,
  output logic bit_strobe
);

  localparam int unsigned CW = $clog2(P_OVERSAMPLE);
  localparam logic [CW-1:0] CntMax = CW'(P_OVERSAMPLE - 1);
  localparam logic [CW-1:0] Smp0   = CW'(P_OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] Smp1   = CW'(P_OVERSAMPLE / 2);
  localparam logic [CW-1:0] Smp2   = CW'(P_OVERSAMPLE / 2 + 1);

  logic [P_SYNC_STAGES-1:0] sync_q;
  logic                     prev_q;
  logic [CW-1:0]            cnt_q;
  logic [1:0]               smp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
      smp_q  <= '0;
    end else begin
      sync_q <= {sync_q[P_SYNC_STAGES-2:0], serial_in};
      prev_q <= synced;
      if (restart || cnt_q == CntMax) cnt_q <= '0;
      else                            cnt_q <= cnt_q + 1'b1;
      if (cnt_q == Smp0) smp_q[0] <= synced;
      if (cnt_q == Smp1) smp_q[1] <= synced;
    end
  end

  assign synced     = sync_q[P_SYNC_STAGES-1];
  assign start_edge = ~synced & prev_q;
  // Third sample is the live synced value, so the vote resolves in this cycle.
  assign bit_value  = (smp_q[0] & smp_q[1]) | (smp_q[0] & synced) | (smp_q[1] & synced);
  assign bit_strobe = (cnt_q == Smp2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity, stop bits and break detection,
// clocked directly by the oversampling baud clock.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned P_DATA_BITS   = 8,
  parameter int unsigned P_PARITY      = 0,
  parameter int unsigned P_STOP_BITS   = 1,
  parameter int unsigned P_OVERSAMPLE  = 16,
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic          x16_BAUD,
  input  logic          reset,
  input  logic          serial_in,
  uart_rx_cfg_if.master rx
);

  localparam logic [3:0] DataLast = 4'(P_DATA_BITS - 1);
  localparam logic [3:0] StopLast = 4'(P_STOP_BITS - 1);

  logic synced, start_edge, bit_value, bit_strobe, restart;

  uart_rx_sampler #(
    .P_OVERSAMPLE (P_OVERSAMPLE),
    .P_SYNC_STAGES(P_SYNC_STAGES)
  ) u_sampler (
    .clk       (x16_BAUD),
    .reset     (reset),
    .serial_in (serial_in),
    .restart   (restart),
    .synced    (synced),
    .start_edge(start_edge),
    .bit_value (bit_value),
    .bit_strobe(bit_strobe)
  );

  logic [2:0]             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [P_DATA_BITS-1:0] shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   zero_q, zero_d;
  logic                   stop_ok_q, stop_ok_d;
  logic                   done, perr, ferr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    zero_d    = zero_q;
    stop_ok_d = stop_ok_q;
    restart   = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StStart;
          restart = 1'b1;
        end
      end
      StStart: begin
        if (bit_strobe) begin
          if (bit_value) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            cnt_d     = '0;
            zero_d    = 1'b1;
            stop_ok_d = 1'b1;
          end
        end
      end
      StData: begin
        if (bit_strobe) begin
          shift_d = {bit_value, shift_q[P_DATA_BITS-1:1]};
          zero_d  = zero_q & ~bit_value;
          if (cnt_q == DataLast) begin
            cnt_d   = '0;
            state_d = (P_PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_strobe) begin
          par_d   = bit_value;
          zero_d  = zero_q & ~bit_value;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_strobe) begin
          stop_ok_d = stop_ok_q & bit_value;
          zero_d    = zero_q & ~bit_value;
          if (cnt_q == StopLast) begin
            // Return to idle at the last stop vote so a new start half a bit later is caught.
            done    = 1'b1;
            cnt_d   = '0;
            state_d = zero_d ? StBreakWait : StIdle;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StBreakWait: begin
        if (synced) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign perr = (P_PARITY != PAR_NONE) && ((^shift_q ^ par_q) != (P_PARITY == PAR_ODD));
  assign ferr = ~stop_ok_d;

  always_ff @(posedge x16_BAUD) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      zero_q        <= 1'b0;
      stop_ok_q     <= 1'b0;
      rx.Do         <= '0;
      rx.valid      <= 1'b0;
      rx.error      <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.break_det  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      zero_q        <= zero_d;
      stop_ok_q     <= stop_ok_d;
      rx.valid      <= done & ~(perr | ferr);
      rx.error      <= done & (perr | ferr);
      rx.parity_err <= done & perr;
      rx.frame_err  <= done & ferr;
      rx.break_det  <= done & zero_d;
      if (done) rx.Do <= shift_q;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: 8N1, 8E1 and 8N2 instances driven with
// directed frames; a negedge monitor pops expectations on every valid/error pulse.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int unsigned OS   = 16;
  localparam int unsigned SYNC = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        ser0  = 1'b1;
  logic        ser1  = 1'b1;
  logic        ser2  = 1'b1;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.P_DATA_BITS(8)) rx0 ();
  uart_rx_cfg_if #(.P_DATA_BITS(8)) rx1 ();
  uart_rx_cfg_if #(.P_DATA_BITS(8)) rx2 ();

  uart_rx_cfg #(.P_DATA_BITS(8), .P_PARITY(PAR_NONE), .P_STOP_BITS(1),
                .P_OVERSAMPLE(OS), .P_SYNC_STAGES(SYNC)) u_8n1 (
    .x16_BAUD(clk), .reset(reset), .serial_in(ser0), .rx(rx0.master));
  uart_rx_cfg #(.P_DATA_BITS(8), .P_PARITY(PAR_EVEN), .P_STOP_BITS(1),
                .P_OVERSAMPLE(OS), .P_SYNC_STAGES(SYNC)) u_8e1 (
    .x16_BAUD(clk), .reset(reset), .serial_in(ser1), .rx(rx1.master));
  uart_rx_cfg #(.P_DATA_BITS(8), .P_PARITY(PAR_NONE), .P_STOP_BITS(2),
                .P_OVERSAMPLE(OS), .P_SYNC_STAGES(SYNC)) u_8n2 (
    .x16_BAUD(clk), .reset(reset), .serial_in(ser2), .rx(rx2.master));

  typedef struct {
    logic [7:0]  data;
    logic        err;
    logic        perr;
    logic        ferr;
    logic        brk;
    int unsigned due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse cycle: one sampling edge, the synchroniser, then the detection-to-pulse latency.
  task automatic push(input int d, input logic [7:0] data, input logic err, input logic perr,
                      input logic ferr, input logic brk, input int unsigned nbits);
    exp_t e;
    e.data = data;
    e.err  = err;
    e.perr = perr;
    e.ferr = ferr;
    e.brk  = brk;
    e.due  = cyc + 1 + SYNC + (nbits - 1) * OS + OS / 2 + 2;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic set_line(input int d, input logic b);
    case (d)
      0:       ser0 = b;
      1:       ser1 = b;
      default: ser2 = b;
    endcase
  endtask

  task automatic send(input int d, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(d, bits[i]);
      repeat (OS) @(negedge clk);
    end
    set_line(d, 1'b1);
  endtask

  task automatic on_pulse(input int d, input logic [7:0] data, input logic v, input logic e,
                          input logic pe, input logic fe, input logic bk);
    exp_t x;
    bit   have = 1'b0;
    case (d)
      0:       if (q0.size() > 0) begin x = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected pulse: got valid=%0b error=%0b Do=%0h expected none",
               d, v, e, data);
    end else begin
      check($sformatf("dut%0d Do", d), 32'(data), 32'(x.data));
      check($sformatf("dut%0d valid/error", d), {30'd0, v, e}, {30'd0, ~x.err, x.err});
      if (x.err)
        check($sformatf("dut%0d flags perr/ferr/brk", d), {29'd0, pe, fe, bk},
              {29'd0, x.perr, x.ferr, x.brk});
      check($sformatf("dut%0d pulse cycle", d), cyc, x.due);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx0.valid || rx0.error)
        on_pulse(0, rx0.Do, rx0.valid, rx0.error, rx0.parity_err, rx0.frame_err, rx0.break_det);
      if (rx1.valid || rx1.error)
        on_pulse(1, rx1.Do, rx1.valid, rx1.error, rx1.parity_err, rx1.frame_err, rx1.break_det);
      if (rx2.valid || rx2.error)
        on_pulse(2, rx2.Do, rx2.valid, rx2.error, rx2.parity_err, rx2.frame_err, rx2.break_det);
    end
  end

  initial begin
    int unsigned n1, ne1, n2;
    n1  = frame_bits(8, PAR_NONE, 1);
    ne1 = frame_bits(8, PAR_EVEN, 1);
    n2  = frame_bits(8, PAR_NONE, 2);

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset Do 8n1", 32'(rx0.Do), 32'h0);
    check("reset valid/error 8n1", {30'd0, rx0.valid, rx0.error}, 32'h0);
    check("reset flags 8n1", {29'd0, rx0.parity_err, rx0.frame_err, rx0.break_det}, 32'h0);
    check("reset Do 8e1", 32'(rx1.Do), 32'h0);
    check("reset Do 8n2", 32'(rx2.Do), 32'h0);
    repeat (20) @(negedge clk);

    // 8N1 good frame with latency check.
    push(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, n1);
    send(0, {1'b1, 8'hA5, 1'b0}, 10);
    repeat (32) @(negedge clk);

    // Short glitch must be rejected, then a real frame.
    ser0 = 1'b0;
    repeat (4) @(negedge clk);
    ser0 = 1'b1;
    repeat (40) @(negedge clk);
    push(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, n1);
    send(0, {1'b1, 8'h3C, 1'b0}, 10);
    repeat (32) @(negedge clk);

    // Back-to-back frames, no idle gap.
    push(0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, n1);
    send(0, {1'b1, 8'h01, 1'b0}, 10);
    push(0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, n1);
    send(0, {1'b1, 8'hFF, 1'b0}, 10);
    repeat (32) @(negedge clk);

    // Break: 30 bit times low gives one error pulse only.
    push(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, n1);
    ser0 = 1'b0;
    repeat (30 * OS) @(negedge clk);
    ser0 = 1'b1;
    repeat (32) @(negedge clk);
    push(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, n1);
    send(0, {1'b1, 8'h81, 1'b0}, 10);
    repeat (32) @(negedge clk);

    // 8E1: good frames, then 0x07 with wrong parity bit 0.
    push(1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, ne1);
    send(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (32) @(negedge clk);
    push(1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, ne1);
    send(1, {1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    repeat (32) @(negedge clk);
    push(1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, ne1);
    send(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (32) @(negedge clk);

    // 8N2: good frame, then second stop bit low.
    push(2, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, n2);
    send(2, {1'b1, 1'b1, 8'h55, 1'b0}, 11);
    repeat (32) @(negedge clk);
    push(2, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, n2);
    send(2, {1'b0, 1'b1, 8'h55, 1'b0}, 11);
    repeat (32) @(negedge clk);

    // Reset during data bit 3 of 0xF0 (line low throughout): no pulse, Do cleared.
    ser0 = 1'b0;
    repeat (OS * 4 + OS / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ser0  = 1'b1;
    @(negedge clk);
    check("Do after mid-frame reset 8n1", 32'(rx0.Do), 32'h0);
    check("Do after reset 8e1", 32'(rx1.Do), 32'h0);
    repeat (48) @(negedge clk);
    push(0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, n1);
    send(0, {1'b1, 8'h12, 1'b0}, 10);
    repeat (64) @(negedge clk);

    check("8n1 leftover expectations", q0.size(), 32'h0);
    check("8e1 leftover expectations", q1.size(), 32'h0);
    check("8n2 leftover expectations", q2.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
